// File: rtl/guess_entry_ctrl.sv
// Keypad guess sequencer: debounce one-hot keys, assemble a NUM_DIGITS guess, compare on ENTER, count misses, lock out.
// Latency: key event registered on the debounce threshold cycle and acted on the next cycle; CHECK and RESULT take one cycle each.
// Backpressure: none; key events arriving in CHECK, RESULT or LOCKED are dropped. `GUESS_LOCK_TIMER_EN adds a timed lockout exit.
module guess_entry_ctrl #(
    parameter int NUM_DIGITS      = 4,
    parameter int MAX_TRIES       = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCK_CYCLES     = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             onehot,
    input  logic [4*NUM_DIGITS-1:0] secret,
    output logic [4*NUM_DIGITS-1:0] disp_digits,
    output logic [3:0]              digit_cnt,
    output logic [7:0]              tries,
    output logic                    match,
    output logic                    miss,
    output logic                    locked,
    output logic                    busy
);
    localparam int W   = 4 * NUM_DIGITS;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES);
    localparam logic [3:0] CODE_ENTER = 4'd10;
    localparam logic [3:0] CODE_CLEAR = 4'd11;

    typedef enum logic [1:0] {ENTRY, CHECK, RESULT, LOCKED} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   disp_q, disp_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [7:0]     tries_q, tries_d, tries_inc;
    logic [15:0]    prev_q, key_q, key_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           fired_q, fired_d, evt_q, evt_d;
    logic           dec_vld;
    logic [3:0]     dec_code;

    // Map a raw keypad word onto a key code; anything else (including multi-hot) is invalid.
    always_comb begin
        dec_vld  = 1'b1;
        dec_code = 4'd0;
        case (key_q)
            16'h0008: dec_code = 4'd0;
            16'h0080: dec_code = 4'd1;
            16'h0040: dec_code = 4'd2;
            16'h0020: dec_code = 4'd3;
            16'h0800: dec_code = 4'd4;
            16'h0400: dec_code = 4'd5;
            16'h0200: dec_code = 4'd6;
            16'h8000: dec_code = 4'd7;
            16'h4000: dec_code = 4'd8;
            16'h2000: dec_code = 4'd9;
            16'h0001: dec_code = CODE_ENTER;
            16'h0002: dec_code = CODE_CLEAR;
            default:  dec_vld  = 1'b0;
        endcase
    end

    // Count identical non-zero samples; fire one event per press, re-armed only by an all-zero sample.
    always_comb begin
        db_cnt_d = '0;
        fired_d  = fired_q;
        evt_d    = 1'b0;
        key_d    = key_q;
        if (onehot == 16'h0000) begin
            fired_d = 1'b0;
        end else if (onehot == prev_q) begin
            db_cnt_d = (db_cnt_q == DB_MAX) ? DB_MAX : db_cnt_q + 1'b1;
        end else begin
            db_cnt_d = DBW'(1);
        end
        if ((db_cnt_d == DB_MAX) && !fired_q) begin
            evt_d   = 1'b1;
            key_d   = onehot;
            fired_d = 1'b1;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            db_cnt_q <= '0;
            fired_q  <= 1'b0;
            evt_q    <= 1'b0;
            key_q    <= '0;
        end else begin
            prev_q   <= onehot;
            db_cnt_q <= db_cnt_d;
            fired_q  <= fired_d;
            evt_q    <= evt_d;
            key_q    <= key_d;
        end
    end

`ifdef GUESS_LOCK_TIMER_EN
    logic [31:0] lock_q, lock_d;
`else
    logic lock_cfg_unused;
    assign lock_cfg_unused = (LOCK_CYCLES > 0);
`endif

    assign tries_inc = (tries_q == 8'hFF) ? 8'hFF : tries_q + 8'd1;

    // Game FSM: next state, datapath updates and the state-decoded pulse/status outputs.
    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        cnt_d   = cnt_q;
        tries_d = tries_q;
        match   = 1'b0;
        miss    = 1'b0;
`ifdef GUESS_LOCK_TIMER_EN
        lock_d  = lock_q;
`endif
        case (state_q)
            ENTRY: begin
                if (evt_q && dec_vld) begin
                    if (dec_code < CODE_ENTER) begin
                        if (cnt_q < 4'(NUM_DIGITS)) begin
                            disp_d = (disp_q << 4) | W'(dec_code);
                            cnt_d  = cnt_q + 4'd1;
                        end
                    end else if (dec_code == CODE_ENTER) begin
                        if (cnt_q == 4'(NUM_DIGITS)) state_d = CHECK;
                    end else begin
                        disp_d = '1;
                        cnt_d  = '0;
                    end
                end
            end
            CHECK: begin
                if (disp_q == secret) begin
                    match   = 1'b1;
                    tries_d = '0;
                    state_d = RESULT;
                end else begin
                    miss    = 1'b1;
                    tries_d = tries_inc;
                    if (tries_inc == 8'(MAX_TRIES)) begin
                        state_d = LOCKED;
`ifdef GUESS_LOCK_TIMER_EN
                        lock_d  = 32'(LOCK_CYCLES - 1);
`endif
                    end else begin
                        state_d = RESULT;
                    end
                end
            end
            RESULT: begin
                disp_d  = '1;
                cnt_d   = '0;
                state_d = ENTRY;
            end
            LOCKED: begin
`ifdef GUESS_LOCK_TIMER_EN
                if (lock_q == 32'd0) begin
                    tries_d = '0;
                    disp_d  = '1;
                    cnt_d   = '0;
                    state_d = ENTRY;
                end else begin
                    lock_d  = lock_q - 32'd1;
                end
`endif
            end
            default: state_d = ENTRY;
        endcase
    end

    // Game state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENTRY;
            disp_q  <= '1;
            cnt_q   <= '0;
            tries_q <= '0;
`ifdef GUESS_LOCK_TIMER_EN
            lock_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            tries_q <= tries_d;
`ifdef GUESS_LOCK_TIMER_EN
            lock_q  <= lock_d;
`endif
        end
    end

    assign disp_digits = disp_q;
    assign digit_cnt   = cnt_q;
    assign tries       = tries_q;
    assign locked      = (state_q == LOCKED);
    assign busy        = (state_q == CHECK);
endmodule
